// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_JMPA = 4'd12;
    localparam logic [3:0] OP_JMPR = 4'd13;

    localparam int FLG_EQ = 0;
    localparam int FLG_AZ = 1;
    localparam int FLG_BZ = 2;
    localparam int FLG_GT = 3;
    localparam int FLG_LT = 4;
    localparam int FLG_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bundle between decode/register-read and the ALU.
interface alu_mc_if #(
    parameter int W     = 16,
    parameter int IMM_W = W / 2
);
    logic             I_valid;
    logic             O_ready;
    logic [4:0]       I_aluop;
    logic [W-1:0]     I_dataA;
    logic [W-1:0]     I_dataB;
    logic [IMM_W-1:0] I_Imm;
    logic             O_valid;
    logic [W-1:0]     O_dataResult;
    logic             O_shldBranch;
    logic             O_carry;
    logic [4:0]       O_flags;

    modport master (
        output I_valid, I_aluop, I_dataA, I_dataB, I_Imm,
        input  O_ready, O_valid, O_dataResult, O_shldBranch, O_carry, O_flags
    );

    modport slave (
        input  I_valid, I_aluop, I_dataA, I_dataB, I_Imm,
        output O_ready, O_valid, O_dataResult, O_shldBranch, O_carry, O_flags
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add multiplier: one partial product per enabled cycle, W iterations.
// Signed mode works on magnitudes and negates the low W bits at the end.
module alu_seq_mul #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_mode,
    output logic [W-1:0] product,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  mcand_q, mplier_q, acc_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q;
    logic          a_neg, b_neg;

    assign a_neg = signed_mode & a[W-1];
    assign b_neg = signed_mode & b[W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else if (en) begin
            if (start) begin
                busy     <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= a_neg ? -a : a;
                mplier_q <= b_neg ? -b : b;
                neg_q    <= a_neg ^ b_neg;
            end else if (done) begin
                busy <= 1'b0;
            end else if (busy) begin
                if (mplier_q[0])
                    acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    // Product is held until the top samples it on the edge after done rises.
    assign done    = busy & (cnt_q == CW'(W));
    assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: valid/ready issue, registered one-cycle result pulse,
// iterative multiplier, carry flag and persistent compare flags for JMPR.
module alu_mc
    import alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int IMM_W = W / 2,
    parameter int SH_W  = $clog2(W)
) (
    input  logic     I_clk,
    input  logic     I_rst,
    input  logic     I_en,
    alu_mc_if.slave  bus
);
    state_t state_q, state_d;

    logic [3:0]       op;
    logic             mode;
    logic [W-1:0]     a, b;
    logic [IMM_W-1:0] imm;
    logic [SH_W-1:0]  sh;

    logic             accept, mul_start, mul_busy, mul_done;
    logic [W-1:0]     mul_product;

    logic [W:0]       sum, diff;
    logic signed [W-1:0] sra;
    logic [FLG_W-1:0] cmp_flags;
    logic [2:0]       jsel;
    logic             jcond;

    logic [W-1:0]     res_c;
    logic             br_c, carry_c;
    logic [FLG_W-1:0] flags_c;

    logic             valid_q, br_q, carry_q;
    logic [W-1:0]     result_q;
    logic [FLG_W-1:0] flags_q;

    assign op   = bus.I_aluop[4:1];
    assign mode = bus.I_aluop[0];
    assign a    = bus.I_dataA;
    assign b    = bus.I_dataB;
    assign imm  = bus.I_Imm;
    assign sh   = b[SH_W-1:0];

    assign bus.O_ready = (state_q == ST_IDLE) & ~mul_busy;
    assign accept      = I_en & bus.I_valid & bus.O_ready;
    assign mul_start   = accept & (op == OP_MUL);

    alu_seq_mul #(.W(W)) u_mul (
        .clk         (I_clk),
        .rst         (I_rst),
        .en          (I_en),
        .start       (mul_start),
        .a           (a),
        .b           (b),
        .signed_mode (mode),
        .product     (mul_product),
        .busy        (mul_busy),
        .done        (mul_done)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst)     state_q <= ST_IDLE;
        else if (I_en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign sra  = $signed(a) >>> sh;

    always_comb begin
        cmp_flags         = '0;
        cmp_flags[FLG_EQ] = (a == b);
        cmp_flags[FLG_AZ] = (a == '0);
        cmp_flags[FLG_BZ] = (b == '0);
        cmp_flags[FLG_GT] = mode ? ($signed(a) > $signed(b)) : (a > b);
        cmp_flags[FLG_LT] = mode ? ($signed(a) < $signed(b)) : (a < b);
    end

    // Selectors 5..7 mean "always taken"; the mode bit inverts either case.
    assign jsel  = imm[2:0];
    assign jcond = (jsel < 3'd5) ? flags_q[jsel] : 1'b1;

    always_comb begin
        res_c   = '0;
        br_c    = 1'b0;
        carry_c = carry_q;
        flags_c = flags_q;
        case (op)
            OP_ADD:  begin res_c = sum[W-1:0];  carry_c = sum[W];  end
            OP_SUB:  begin res_c = diff[W-1:0]; carry_c = diff[W]; end
            OP_OR:   res_c = a | b;
            OP_AND:  res_c = a & b;
            OP_XOR:  res_c = a ^ b;
            OP_NOT:  res_c = ~a;
            OP_LOAD: res_c = mode ? {imm, {(W-IMM_W){1'b0}}} : {{(W-IMM_W){1'b0}}, imm};
            OP_CMP:  begin
                res_c   = {{(W-FLG_W){1'b0}}, cmp_flags};
                flags_c = cmp_flags;
            end
            OP_SHL:  res_c = a << sh;
            OP_SHR:  res_c = mode ? sra : (a >> sh);
            OP_JMPA: begin
                res_c = mode ? a : {{(W-IMM_W){1'b0}}, imm};
                br_c  = 1'b1;
            end
            OP_JMPR: begin
                res_c = a;
                br_c  = jcond ^ mode;
            end
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            br_q     <= 1'b0;
            carry_q  <= 1'b0;
            flags_q  <= '0;
        end else if (I_en) begin
            valid_q <= 1'b0;
            if (accept && op != OP_MUL) begin
                valid_q  <= 1'b1;
                result_q <= res_c;
                br_q     <= br_c;
                carry_q  <= carry_c;
                flags_q  <= flags_c;
            end else if (state_q == ST_MUL && mul_done) begin
                valid_q  <= 1'b1;
                result_q <= mul_product;
                br_q     <= 1'b0;
            end
        end
    end

    assign bus.O_valid      = valid_q;
    assign bus.O_dataResult = result_q;
    assign bus.O_shldBranch = br_q;
    assign bus.O_carry      = carry_q;
    assign bus.O_flags      = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors checked with immediate assertions.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, en;
    int   checks = 0;
    int   errors = 0;
    int   n, seen;

    always #5 clk = ~clk;

    alu_mc_if #(.W(W)) bus ();

    alu_mc #(.W(W)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .I_en  (en),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic mode,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] imm);
        bus.I_valid = 1'b1;
        bus.I_aluop = {op, mode};
        bus.I_dataA = a;
        bus.I_dataB = b;
        bus.I_Imm   = imm;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        bus.I_valid = 1'b0;
        bus.I_aluop = '0;
        bus.I_dataA = '0;
        bus.I_dataB = '0;
        bus.I_Imm   = '0;
        step();
        step();
        chk("rst_valid", 32'(bus.O_valid), 32'h0);
        chk("rst_result", 32'(bus.O_dataResult), 32'h0);
        chk("rst_branch", 32'(bus.O_shldBranch), 32'h0);
        chk("rst_carry", 32'(bus.O_carry), 32'h0);
        chk("rst_flags", 32'(bus.O_flags), 32'h0);
        chk("rst_ready", 32'(bus.O_ready), 32'h1);
        rst = 1'b0;

        // ADD with carry out, then valid drops
        issue(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 8'h00);
        step();
        bus.I_valid = 1'b0;
        chk("add_valid", 32'(bus.O_valid), 32'h1);
        chk("add_result", 32'(bus.O_dataResult), 32'h0000);
        chk("add_carry", 32'(bus.O_carry), 32'h1);
        chk("add_branch", 32'(bus.O_shldBranch), 32'h0);
        step();
        chk("add_valid_drop", 32'(bus.O_valid), 32'h0);

        issue(OP_SUB, 1'b0, 16'h0001, 16'h0002, 8'h00);
        step();
        chk("sub_result", 32'(bus.O_dataResult), 32'hFFFF);
        chk("sub_borrow", 32'(bus.O_carry), 32'h1);

        // CMP followed back-to-back by JMPR variants
        issue(OP_CMP, 1'b1, 16'hFFFE, 16'h0003, 8'h00);
        step();
        chk("cmps_result", 32'(bus.O_dataResult), 32'h0010);
        chk("cmps_flags", 32'(bus.O_flags), 32'h10);
        issue(OP_JMPR, 1'b0, 16'h0040, 16'h0000, 8'h04);
        step();
        chk("jmpr_lt_result", 32'(bus.O_dataResult), 32'h0040);
        chk("jmpr_lt_branch", 32'(bus.O_shldBranch), 32'h1);
        issue(OP_JMPR, 1'b0, 16'h0040, 16'h0000, 8'h00);
        step();
        chk("jmpr_eq_branch", 32'(bus.O_shldBranch), 32'h0);
        issue(OP_JMPR, 1'b1, 16'h0040, 16'h0000, 8'h00);
        step();
        chk("jmpr_neq_branch", 32'(bus.O_shldBranch), 32'h1);
        issue(OP_JMPR, 1'b0, 16'h1234, 16'h0000, 8'h07);
        step();
        chk("jmpr_uncond_result", 32'(bus.O_dataResult), 32'h1234);
        chk("jmpr_uncond_branch", 32'(bus.O_shldBranch), 32'h1);
        issue(OP_CMP, 1'b0, 16'hFFFE, 16'h0003, 8'h00);
        step();
        chk("cmpu_result", 32'(bus.O_dataResult), 32'h0008);
        issue(OP_LOAD, 1'b1, 16'h0000, 16'h0000, 8'h12);
        step();
        chk("load_hi", 32'(bus.O_dataResult), 32'h1200);
        chk("load_branch", 32'(bus.O_shldBranch), 32'h0);
        issue(OP_NOT, 1'b0, 16'h00FF, 16'h0000, 8'h00);
        step();
        chk("not_result", 32'(bus.O_dataResult), 32'hFF00);
        bus.I_valid = 1'b0;
        step();

        // Signed MUL: W+1 cycles not ready, mid-multiply offer ignored
        issue(OP_MUL, 1'b1, 16'hFFFD, 16'h0007, 8'h00);
        step();
        bus.I_valid = 1'b0;
        chk("mul_ready_e0", 32'(bus.O_ready), 32'h0);
        chk("mul_valid_e0", 32'(bus.O_valid), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) issue(OP_ADD, 1'b0, 16'h0001, 16'h0001, 8'h00);
            step();
            if (i == 8) bus.I_valid = 1'b0;
            chk("mul_ready_busy", 32'(bus.O_ready), 32'h0);
            chk("mul_valid_busy", 32'(bus.O_valid), 32'h0);
        end
        step();
        chk("mul_valid", 32'(bus.O_valid), 32'h1);
        chk("mul_result", 32'(bus.O_dataResult), 32'hFFEB);
        chk("mul_ready_back", 32'(bus.O_ready), 32'h1);
        chk("mul_branch", 32'(bus.O_shldBranch), 32'h0);
        step();
        chk("mul_no_extra", 32'(bus.O_valid), 32'h0);

        issue(OP_MUL, 1'b0, 16'h0123, 16'h0010, 8'h00);
        step();
        bus.I_valid = 1'b0;
        n = 0;
        while (!bus.O_valid && n < 40) begin
            step();
            n++;
        end
        chk("mulu_latency", 32'(n), 32'd17);
        chk("mulu_result", 32'(bus.O_dataResult), 32'h1230);

        // Shifts
        issue(OP_SHR, 1'b1, 16'h8000, 16'h0004, 8'h00);
        step();
        chk("sra_result", 32'(bus.O_dataResult), 32'hF800);
        issue(OP_SHR, 1'b0, 16'h8000, 16'h0004, 8'h00);
        step();
        chk("srl_result", 32'(bus.O_dataResult), 32'h0800);
        issue(OP_SHL, 1'b0, 16'h0001, 16'h001F, 8'h00);
        step();
        chk("shl_result", 32'(bus.O_dataResult), 32'h8000);
        bus.I_valid = 1'b0;

        // Reset aborts a MUL in flight
        issue(OP_MUL, 1'b0, 16'h0005, 16'h0006, 8'h00);
        step();
        bus.I_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", 32'(bus.O_valid), 32'h0);
        chk("abort_ready", 32'(bus.O_ready), 32'h1);
        chk("abort_result", 32'(bus.O_dataResult), 32'h0);
        chk("abort_flags", 32'(bus.O_flags), 32'h0);
        chk("abort_carry", 32'(bus.O_carry), 32'h0);
        seen = 0;
        repeat (20) begin
            step();
            if (bus.O_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        issue(OP_ADD, 1'b0, 16'h0002, 16'h0003, 8'h00);
        step();
        chk("post_abort_add", 32'(bus.O_dataResult), 32'h0005);
        chk("post_abort_carry", 32'(bus.O_carry), 32'h0);

        // Stall holds the result pulse; the offer made during the stall is not taken
        issue(OP_XOR, 1'b0, 16'hF0F0, 16'h0FF0, 8'h00);
        step();
        chk("xor_valid", 32'(bus.O_valid), 32'h1);
        chk("xor_result", 32'(bus.O_dataResult), 32'hFF00);
        issue(OP_ADD, 1'b0, 16'h0001, 16'h0001, 8'h00);
        en = 1'b0;
        repeat (3) begin
            step();
            chk("stall_valid", 32'(bus.O_valid), 32'h1);
            chk("stall_result", 32'(bus.O_dataResult), 32'hFF00);
        end
        bus.I_valid = 1'b0;
        en = 1'b1;
        step();
        chk("unstall_valid", 32'(bus.O_valid), 32'h0);
        chk("unstall_result", 32'(bus.O_dataResult), 32'hFF00);

        // Illegal opcodes leave flags and carry alone
        issue(OP_CMP, 1'b0, 16'h0005, 16'h0005, 8'h00);
        step();
        chk("cmp_eq_result", 32'(bus.O_dataResult), 32'h0001);
        issue(OP_JMPA, 1'b0, 16'h4444, 16'h0000, 8'hAB);
        step();
        chk("jmpa_result", 32'(bus.O_dataResult), 32'h00AB);
        chk("jmpa_branch", 32'(bus.O_shldBranch), 32'h1);
        issue(4'd7, 1'b0, 16'h0003, 16'h0003, 8'h00);
        step();
        chk("ill7_valid", 32'(bus.O_valid), 32'h1);
        chk("ill7_result", 32'(bus.O_dataResult), 32'h0);
        chk("ill7_branch", 32'(bus.O_shldBranch), 32'h0);
        chk("ill7_flags", 32'(bus.O_flags), 32'h01);
        chk("ill7_carry", 32'(bus.O_carry), 32'h0);
        issue(4'd15, 1'b1, 16'h1111, 16'h2222, 8'h00);
        step();
        bus.I_valid = 1'b0;
        chk("ill15_result", 32'(bus.O_dataResult), 32'h0);
        chk("ill15_flags", 32'(bus.O_flags), 32'h01);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
